booth_pp_accumulator: RTL and testbench

- Sequential radix-4 Booth multiplier controller; the consumer side of the team's combinational Booth partial-product encoder.
- Latches an unsigned multiplicand X and a signed two's-complement multiplier Y.
- Drives one Booth triplet per cycle to the encoder and accepts the returned 16-bit partial product the same cycle.
- Shifts each partial product by 2*i, accumulates, and presents the product through a valid/ready output.

---
 rtl/booth_pp_accumulator.sv | 75 +++++++
 tb/tb_booth_pp_accumulator.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator: sequential radix-4 Booth multiplier controller, one external-encoder partial product per cycle
// Optional BOOTH_ZERO_SKIP_EN: a zero operand bypasses RUN and completes one cycle after acceptance.
module booth_pp_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x_in,
  input  logic [WIDTH-1:0]     y_in,
  output logic [WIDTH-1:0]     enc_x,
  output logic [2:0]           enc_operand,
  input  logic [2*WIDTH-1:0]   enc_pp,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);
  localparam int DIGITS = WIDTH / 2;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] x_r, y_r;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0] i;
  logic [WIDTH:0] y_ext;
  assign y_ext = {y_r, 1'b0};
  // triplet {y[2i+1], y[2i], y[2i-1]} with y[-1] = 0 supplied by the appended zero
  assign enc_operand = (state == RUN) ? 3'(y_ext >> {i, 1'b0}) : 3'b000;
  assign enc_x = x_r;
  assign acc_nxt = acc + (enc_pp << {i, 1'b0});
  assign in_ready = (state == IDLE);
  assign busy = (state != IDLE);
  assign out_valid = (state == DONE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x_r <= '0;
      y_r <= '0;
      acc <= '0;
      i <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_r <= x_in;
          y_r <= y_in;
          acc <= '0;
          i <= '0;
`ifdef BOOTH_ZERO_SKIP_EN
          if (x_in == '0 || y_in == '0) begin
            product <= '0;
            state <= DONE;
          end else begin
            state <= RUN;
          end
`else
          state <= RUN;
`endif
        end
        RUN: begin
          acc <= acc_nxt;
          i <= i + 1'b1;
          if (i == CW'(DIGITS - 1)) begin
            product <= acc_nxt;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_pp_accumulator.sv
// tb_booth_pp_accumulator: table vectors, corner sequences and random operands against a plain signed multiply
module tb_booth_pp_accumulator;
  logic clk, rst_n, in_valid, in_ready, busy, out_valid, out_ready;
  logic [7:0] x_in, y_in, enc_x;
  logic [2:0] enc_operand;
  logic [15:0] enc_pp, product;
  int total, bad;

  booth_pp_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .enc_x(enc_x), .enc_operand(enc_operand),
    .enc_pp(enc_pp), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .product(product)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [2:0] t, input logic [7:0] x);
    int d;
    d = int'(t[1]) + int'(t[0]) - 2 * int'(t[2]);
    return 16'(d * int'(x));
  endfunction
  always_comb enc_pp = enc(enc_operand, enc_x);

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int yi;
    yi = $signed(y);
    return 16'(int'(x) * yi);
  endfunction

  function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y);
`ifdef BOOTH_ZERO_SKIP_EN
    if (x == 0 || y == 0) return 1;
`endif
    return 5;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input bit rnd);
    int lat, n;
    bit hs;
    chk("in_ready_before", in_ready, 1);
    in_valid = 1; x_in = x; y_in = y;
    tick();
    in_valid = 0; lat = 1;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    chk("latency", lat, exp_lat(x, y));
    chk("product", product, exp);
    n = 0;
    do begin
      out_ready = (rnd && n < 30) ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = out_ready;
      tick();
      n++;
    end while (!hs);
    chk("idle_after_hs", {out_valid, in_ready}, 2'b01);
  endtask

  // out_valid and product must hold whenever a valid result was not taken
  logic mv, mr;
  logic [15:0] mp;
  always @(posedge clk) begin
    mv = out_valid; mr = out_ready; mp = product;
    #1;
    if (rst_n && mv && !mr) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_product", product, mp);
    end
  end

  typedef struct { logic [7:0] x; logic [7:0] y; logic [15:0] p; } vec_t;
  vec_t tbl[8];
  logic [2:0] seq[4];

  initial begin
    int lat;
    bit seen;
    logic [7:0] rx, ry;
    tbl[0] = '{8'd3, 8'd5, 16'h000F};
    tbl[1] = '{8'd255, 8'h80, 16'h8080};
    tbl[2] = '{8'd255, 8'h7F, 16'h7E81};
    tbl[3] = '{8'h81, 8'hFF, 16'hFF7F};
    tbl[4] = '{8'd7, 8'd7, 16'h0031};
    tbl[5] = '{8'd0, 8'h55, 16'h0000};
    tbl[6] = '{8'd2, 8'hFE, 16'hFFFC};
    tbl[7] = '{8'h55, 8'h00, 16'h0000};
    seq[0] = 3'b010; seq[1] = 3'b010; seq[2] = 3'b000; seq[3] = 3'b000;
    total = 0; bad = 0;
    rst_n = 0; in_valid = 0; out_ready = 1; x_in = 0; y_in = 0;
    #3;
    chk("rst_product", product, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enc_operand", enc_operand, 0);
    chk("rst_enc_x", enc_x, 0);
    #19 rst_n = 1;
    tick();
    chk("in_ready_after_rst", in_ready, 1);

    in_valid = 1; x_in = 3; y_in = 5;
    tick();
    in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      chk("enc_operand_seq", enc_operand, seq[k]);
      chk("enc_x_stable", enc_x, 3);
      chk("busy_run", {busy, in_ready, out_valid}, 3'b100);
      tick();
    end
    chk("seq_out_valid", out_valid, 1);
    chk("seq_product", product, 16'h000F);
    tick();
    chk("seq_idle", in_ready, 1);

    for (int k = 0; k < 8; k++) op(tbl[k].x, tbl[k].y, tbl[k].p, 0);

    out_ready = 0; in_valid = 1; x_in = 12; y_in = 8'hFD;
    tick();
    in_valid = 0; lat = 1;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    chk("bp_latency", lat, 5);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1; x_in = 8'($urandom); y_in = 8'($urandom);
      tick();
      chk("bp_product", product, 16'hFFDC);
      chk("bp_flags", {out_valid, in_ready, busy}, 3'b101);
    end
    in_valid = 0; out_ready = 1;
    tick();
    chk("bp_release", {out_valid, in_ready, busy}, 3'b010);
    chk("bp_product_kept", product, 16'hFFDC);

    in_valid = 1; x_in = 100; y_in = 100;
    tick();
    in_valid = 0;
    tick();
    #2 rst_n = 0;
    #1;
    chk("midrun_product", product, 0);
    chk("midrun_flags", {out_valid, busy}, 2'b00);
    chk("midrun_enc", {enc_x, enc_operand}, 11'd0);
    seen = 0;
    repeat (3) begin tick(); seen |= out_valid; end
    #3 rst_n = 1;
    repeat (6) begin tick(); seen |= out_valid; end
    chk("midrun_no_valid", seen, 0);
    op(8'd7, 8'd7, 16'h0031, 0);

    for (int k = 0; k < 3000; k++) begin
      rx = 8'($urandom); ry = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rx = 0;
      if ($urandom_range(0, 15) == 0) ry = 0;
      op(rx, ry, ref_mul(rx, ry), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
